// File: rtl/qq_cmd_ctrl.sv
// qq_cmd_ctrl
//   Sequences one user command at a time (ENQ / DEQ / REPL) into a queue node.
//   Each command is checked against the node flags, then issued as a
//   single-cycle strobe once the node is ready. The controller then waits for
//   the node to become ready again and returns a response holding a key and an
//   error code.
//
// Optional feature (macro QQ_CMD_TIMEOUT_EN):
//   Bounds the time spent in ISSUE + WAIT1 to TO cycles. On expiry the command
//   ends with err 11 and an all-ones key. Without the macro there is no
//   counter, the controller waits indefinitely, and TO is not used.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   cmd_valid_i/ready_o   command handshake; cmd_op_i, cmd_key_i payload
//   q_rdy_i, q_full_i, q_empty_i, q_head_i   node status and head key
//   q_enq_o, q_deq_o, q_repl_o, q_data_o     node strobes and data
//   rsp_valid_o/ready_i   response handshake; rsp_key_o, rsp_err_o payload
//   count_o               tracked occupancy, saturating at 0 and D
module qq_cmd_ctrl #(
    parameter int W  = 32,
    parameter int D  = 4,
    parameter int TO = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [1:0]             cmd_op_i,
    input  logic [W-1:0]           cmd_key_i,
    input  logic                   q_rdy_i,
    input  logic                   q_full_i,
    input  logic                   q_empty_i,
    input  logic [W-1:0]           q_head_i,
    output logic                   q_enq_o,
    output logic                   q_deq_o,
    output logic                   q_repl_o,
    output logic [W-1:0]           q_data_o,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [W-1:0]           rsp_key_o,
    output logic [1:0]             rsp_err_o,
    output logic [$clog2(D+1)-1:0] count_o
);

    localparam int            CW      = $clog2(D + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(D);

    localparam logic [1:0] OP_ENQ  = 2'b00;
    localparam logic [1:0] OP_DEQ  = 2'b01;
    localparam logic [1:0] OP_REPL = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_FULL  = 2'b01;
    localparam logic [1:0] ERR_EMPTY = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    if (D < 1) begin : g_bad_d
        $error("qq_cmd_ctrl: D must be at least 1");
    end
    if (TO < 2) begin : g_bad_to
        $error("qq_cmd_ctrl: TO must be at least 2");
    end

    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT0, WAIT1, RESP} state_t;

    state_t          state, state_nxt;
    logic [1:0]      op_r;
    logic [W-1:0]    key_r;
    logic [W-1:0]    rsp_key_r;
    logic [1:0]      rsp_err_r;
    logic [CW-1:0]   count_r;
    logic            reject;
    logic [1:0]      reject_err;
    logic [W-1:0]    reject_key;
    logic            tmo;

    // Reset asserts asynchronously but releases two clk edges after rst_n
    // rises; every other flop in the block resets from rst_sync.
    logic rst_meta, rst_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

`ifdef QQ_CMD_TIMEOUT_EN
    localparam int            TW       = $clog2(TO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TO - 1);

    logic [TW-1:0] tmo_cnt;

    // CHECK is the only way into ISSUE, so clearing there clears on entry.
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            tmo_cnt <= '0;
        end else if (state == CHECK) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE || state == WAIT1) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Fires during the TO-th counted cycle; a ready node in that same cycle wins.
    assign tmo = (state == ISSUE || state == WAIT1) && (tmo_cnt == TMO_LAST);
`else
    assign tmo = 1'b0;
`endif

    // Rejection decision taken in CHECK from the latched op and live flags.
    always_comb begin
        reject     = 1'b1;
        reject_err = ERR_TMO;
        reject_key = '1;
        case (op_r)
            OP_ENQ: begin
                reject     = q_full_i;
                reject_err = ERR_FULL;
                reject_key = key_r;
            end
            OP_DEQ, OP_REPL: begin
                reject     = q_empty_i;
                reject_err = ERR_EMPTY;
                reject_key = '1;
            end
            OP_RSV: begin
                reject     = 1'b1;
                reject_err = ERR_TMO;
                reject_key = '1;
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid_i && cmd_ready_o) state_nxt = CHECK;
            CHECK:   state_nxt = reject ? RESP : ISSUE;
            ISSUE:   if (q_rdy_i) state_nxt = WAIT0;
                     else if (tmo) state_nxt = RESP;
            WAIT0:   state_nxt = WAIT1;
            WAIT1:   if (q_rdy_i || tmo) state_nxt = RESP;
            RESP:    if (rsp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic. cmd_ready_o reads 1 while rst_n is held low, but 0 during
    // the release window so no handshake appears to be taken early.
    always_comb begin
        cmd_ready_o = 1'b0;
        q_enq_o     = 1'b0;
        q_deq_o     = 1'b0;
        q_repl_o    = 1'b0;
        q_data_o    = '0;
        rsp_valid_o = 1'b0;
        case (state)
            IDLE:  cmd_ready_o = rst_sync | ~rst_n;
            CHECK, WAIT0, WAIT1: q_data_o = key_r;
            ISSUE: begin
                q_data_o = key_r;
                if (q_rdy_i) begin
                    q_enq_o  = (op_r == OP_ENQ);
                    q_deq_o  = (op_r == OP_DEQ);
                    q_repl_o = (op_r == OP_REPL);
                end
            end
            RESP:  rsp_valid_o = 1'b1;
            default: ;
        endcase
    end

    // Command latch, response capture and occupancy tracking.
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            op_r      <= OP_ENQ;
            key_r     <= '0;
            rsp_key_r <= '0;
            rsp_err_r <= ERR_OK;
            count_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        op_r  <= cmd_op_i;
                        key_r <= cmd_key_i;
                    end
                end
                CHECK: begin
                    if (reject) begin
                        rsp_err_r <= reject_err;
                        rsp_key_r <= reject_key;
                    end
                end
                ISSUE: begin
                    if (q_rdy_i) begin
                        rsp_key_r <= (op_r == OP_ENQ) ? key_r : q_head_i;
                    end else if (tmo) begin
                        rsp_err_r <= ERR_TMO;
                        rsp_key_r <= '1;
                    end
                end
                WAIT1: begin
                    if (q_rdy_i) begin
                        rsp_err_r <= ERR_OK;
                        if (op_r == OP_ENQ && count_r != CNT_MAX) begin
                            count_r <= count_r + CW'(1);
                        end else if (op_r == OP_DEQ && count_r != '0) begin
                            count_r <= count_r - CW'(1);
                        end
                    end else if (tmo) begin
                        rsp_err_r <= ERR_TMO;
                        rsp_key_r <= '1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_key_o = rsp_key_r;
    assign rsp_err_o = rsp_err_r;
    assign count_o   = count_r;

endmodule

// File: tb/tb_qq_cmd_ctrl.sv
// Bench for qq_cmd_ctrl: directed vector table, randomized commands against a
// transaction-level model, plus reset-release and timeout sequences.
module tb_qq_cmd_ctrl;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_key;
    logic        q_rdy;
    logic        q_full;
    logic        q_empty;
    logic [31:0] q_head;
    logic        q_enq;
    logic        q_deq;
    logic        q_repl;
    logic [31:0] q_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_key;
    logic [1:0]  rsp_err;
    logic [2:0]  count;

    int n_errors = 0;
    int n_checks = 0;
    int model_cnt = 0;

    qq_cmd_ctrl #(.W(32), .D(DEPTH), .TO(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_key_i(cmd_key),
        .q_rdy_i(q_rdy), .q_full_i(q_full), .q_empty_i(q_empty), .q_head_i(q_head),
        .q_enq_o(q_enq), .q_deq_o(q_deq), .q_repl_o(q_repl), .q_data_o(q_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_key_o(rsp_key), .rsp_err_o(rsp_err), .count_o(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Whole-transaction reference: result of one command given node flags.
    // kind: 0 none, 1 enq, 2 deq, 3 repl.
    function automatic void model(input logic [1:0] op, input logic [31:0] key,
                                  input logic full, input logic empty,
                                  input logic [31:0] head, input int cnt_in,
                                  output int kind, output logic [31:0] rkey,
                                  output logic [1:0] err, output int cnt_out);
        kind = 0; rkey = 32'hFFFF_FFFF; err = 2'd3; cnt_out = cnt_in;
        if (op == 2'd0) begin
            rkey = key;
            if (full) err = 2'd1;
            else begin kind = 1; err = 2'd0; cnt_out = (cnt_in < DEPTH) ? cnt_in + 1 : DEPTH; end
        end else if (op == 2'd1) begin
            if (empty) err = 2'd2;
            else begin kind = 2; rkey = head; err = 2'd0; cnt_out = (cnt_in > 0) ? cnt_in - 1 : 0; end
        end else if (op == 2'd2) begin
            if (empty) err = 2'd2;
            else begin kind = 3; rkey = head; err = 2'd0; end
        end
    endfunction

    // rdy_mode: 0 always ready, 1 random (max 2-cycle stalls),
    //           2 ready until the strobe then never, 3 never ready.
    // e_rsp_cyc: cycle (after handshake edge) rsp_valid must first appear; 0 = any.
    task automatic run_cmd(input logic [1:0] op, input logic [31:0] key,
                           input logic full, input logic empty, input logic [31:0] head,
                           input int rdy_mode, input int hold,
                           input int e_kind, input logic [31:0] e_key,
                           input logic [1:0] e_err, input int e_cnt,
                           input int e_rsp_cyc, input string tag);
        int waited, n_str, seen_kind, str_cyc, rsp_cyc, stall;
        logic excl_bad, hold_bad;
        logic [31:0] sdata, hk;
        logic [1:0] he;
        @(posedge clk); #1;
        cmd_op = op; cmd_key = key; q_full = full; q_empty = empty; q_head = head;
        q_rdy = (rdy_mode != 3); cmd_valid = 1'b1;
        @(negedge clk);
        waited = 0;
        while (!cmd_ready && waited < 20) begin @(negedge clk); waited++; end
        chk({tag, "_accept"}, 32'(cmd_ready), 32'd1);
        if (!cmd_ready) begin cmd_valid = 1'b0; return; end
        n_str = 0; seen_kind = 0; str_cyc = 0; rsp_cyc = 0; stall = 0;
        excl_bad = 1'b0; sdata = '0;
        for (int cy = 1; cy <= 200 && rsp_cyc == 0; cy++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            case (rdy_mode)
                0: q_rdy = 1'b1;
                1: begin
                    q_rdy = (stall >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
                    stall = q_rdy ? 0 : stall + 1;
                end
                2: q_rdy = (n_str == 0);
                default: q_rdy = 1'b0;
            endcase
            @(negedge clk);
            if (int'(q_enq) + int'(q_deq) + int'(q_repl) > 1) excl_bad = 1'b1;
            if (q_enq || q_deq || q_repl) begin
                n_str++; str_cyc = cy; sdata = q_data;
                seen_kind = q_enq ? 1 : (q_deq ? 2 : 3);
            end
            if (rsp_valid) rsp_cyc = cy;
        end
        chk({tag, "_rsp_seen"}, 32'(rsp_cyc != 0), 32'd1);
        if (rsp_cyc == 0) return;
        chk({tag, "_strobe_excl"}, 32'(excl_bad), 32'd0);
        chk({tag, "_strobe_count"}, 32'(n_str), 32'(e_kind != 0));
        if (e_kind != 0) begin
            chk({tag, "_strobe_kind"}, 32'(seen_kind), 32'(e_kind));
            chk({tag, "_strobe_data"}, sdata, key);
            if (e_rsp_cyc != 0) chk({tag, "_strobe_cycle"}, 32'(str_cyc), 32'd2);
        end
        if (e_rsp_cyc != 0) chk({tag, "_rsp_cycle"}, 32'(rsp_cyc), 32'(e_rsp_cyc));
        chk({tag, "_rsp_key"}, rsp_key, e_key);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(e_err));
        chk({tag, "_count"}, 32'(count), 32'(e_cnt));
        hk = rsp_key; he = rsp_err; hold_bad = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (!rsp_valid || rsp_key !== hk || rsp_err !== he || cmd_ready) hold_bad = 1'b1;
        end
        if (hold > 0) chk({tag, "_rsp_hold"}, 32'(hold_bad), 32'd0);
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_no_ready_in_resp"}, 32'(cmd_ready), 32'd0);
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_valid_after"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_idle_data"}, q_data, 32'd0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] key;
        logic        full;
        logic        empty;
        logic [31:0] head;
        int          hold;
        int          kind;
        logic [31:0] ekey;
        logic [1:0]  err;
        int          cnt;
    } vec_t;

    vec_t tbl[17];

    initial begin : main
        int ek, ecnt, hold, first, rcyc;
        logic [31:0] ekey, rkey;
        logic [1:0] eerr, op;
        logic full, empty, hs;

        tbl[0]  = '{2'd0, 32'h10, 1'b0, 1'b0, 32'h0,  0, 1, 32'h10,        2'd0, 1};
        tbl[1]  = '{2'd0, 32'h05, 1'b0, 1'b0, 32'h0,  1, 1, 32'h05,        2'd0, 2};
        tbl[2]  = '{2'd0, 32'h20, 1'b0, 1'b0, 32'h0,  0, 1, 32'h20,        2'd0, 3};
        tbl[3]  = '{2'd1, 32'h00, 1'b0, 1'b0, 32'h05, 5, 2, 32'h05,        2'd0, 2};
        tbl[4]  = '{2'd1, 32'h00, 1'b0, 1'b1, 32'h05, 0, 0, 32'hFFFF_FFFF, 2'd2, 2};
        tbl[5]  = '{2'd0, 32'h07, 1'b1, 1'b0, 32'h0,  2, 0, 32'h07,        2'd1, 2};
        tbl[6]  = '{2'd2, 32'h44, 1'b0, 1'b0, 32'h33, 0, 3, 32'h33,        2'd0, 2};
        tbl[7]  = '{2'd3, 32'h09, 1'b0, 1'b0, 32'h0,  0, 0, 32'hFFFF_FFFF, 2'd3, 2};
        tbl[8]  = '{2'd0, 32'h01, 1'b0, 1'b0, 32'h0,  0, 1, 32'h01,        2'd0, 3};
        tbl[9]  = '{2'd0, 32'h02, 1'b0, 1'b0, 32'h0,  0, 1, 32'h02,        2'd0, 4};
        tbl[10] = '{2'd0, 32'h03, 1'b0, 1'b0, 32'h0,  0, 1, 32'h03,        2'd0, 4};
        tbl[11] = '{2'd1, 32'h00, 1'b0, 1'b0, 32'hA1, 0, 2, 32'hA1,        2'd0, 3};
        tbl[12] = '{2'd1, 32'h00, 1'b0, 1'b0, 32'hA2, 0, 2, 32'hA2,        2'd0, 2};
        tbl[13] = '{2'd1, 32'h00, 1'b0, 1'b0, 32'hA3, 0, 2, 32'hA3,        2'd0, 1};
        tbl[14] = '{2'd1, 32'h00, 1'b0, 1'b0, 32'hA4, 0, 2, 32'hA4,        2'd0, 0};
        tbl[15] = '{2'd1, 32'h00, 1'b0, 1'b0, 32'hA5, 0, 2, 32'hA5,        2'd0, 0};
        tbl[16] = '{2'd2, 32'h55, 1'b0, 1'b1, 32'hA6, 0, 0, 32'hFFFF_FFFF, 2'd2, 0};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_key = '0;
        q_rdy = 1'b0; q_full = 1'b0; q_empty = 1'b0; q_head = '0; rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_strobes", 32'({q_enq, q_deq, q_repl}), 32'd0);
        chk("rst_q_data", q_data, 32'd0);
        chk("rst_rsp_key", rsp_key, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Directed vectors, node always ready: exact latencies checked
        foreach (tbl[i]) begin
            run_cmd(tbl[i].op, tbl[i].key, tbl[i].full, tbl[i].empty, tbl[i].head,
                    0, tbl[i].hold, tbl[i].kind, tbl[i].ekey, tbl[i].err, tbl[i].cnt,
                    (tbl[i].kind != 0) ? 5 : 2, $sformatf("vec%0d", i));
        end
        model_cnt = 0;

        // Randomized commands with random node stalls
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            full = ($urandom_range(0, 3) == 0);
            empty = ($urandom_range(0, 3) == 0);
            rkey = $urandom;
            ekey = $urandom;
            hold = $urandom_range(0, 3);
            model(op, rkey, full, empty, ekey, model_cnt, ek, ekey, eerr, ecnt);
            run_cmd(op, rkey, full, empty, q_head_of(op, ekey, rkey), 1, hold,
                    ek, ekey, eerr, ecnt, 0, "rnd");
            model_cnt = ecnt;
        end

        // Reset asserted while waiting in WAIT1
        @(posedge clk); #1;
        cmd_op = 2'd0; cmd_key = 32'h5A; q_full = 1'b0; q_empty = 1'b0; q_rdy = 1'b1;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("rm_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rm_strobe", 32'(q_enq), 32'd1);
        @(posedge clk); #1 q_rdy = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rm_wait1_data", q_data, 32'h5A);
        chk("rm_wait1_no_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk); #2 rst_n = 1'b0; #1;
        chk("rm_rst_ready", 32'(cmd_ready), 32'd1);
        chk("rm_rst_valid", 32'(rsp_valid), 32'd0);
        chk("rm_rst_data", q_data, 32'd0);
        chk("rm_rst_count", 32'(count), 32'd0);
        chk("rm_rst_key", rsp_key, 32'd0);

        // Release with a command already pending: handshake must wait for sync
        repeat (2) @(posedge clk);
        #1 cmd_op = 2'd0; cmd_key = 32'h66; q_rdy = 1'b1; cmd_valid = 1'b1;
        #2 rst_n = 1'b1;
        first = 0; hs = 1'b0; rcyc = 0;
        for (int e = 1; e <= 15 && rcyc == 0; e++) begin
            @(posedge clk); #1;
            if (hs) cmd_valid = 1'b0;
            @(negedge clk);
            if (q_enq && first == 0) first = e;
            if (cmd_valid && cmd_ready) hs = 1'b1;
            if (rsp_valid) rcyc = e;
        end
        chk("rel_strobe_seen", 32'(first != 0), 32'd1);
        chk("rel_not_early", 32'(first >= 3), 32'd1);
        chk("rel_rsp_seen", 32'(rcyc != 0), 32'd1);
        chk("rel_rsp_err", 32'(rsp_err), 32'd0);
        chk("rel_rsp_key", rsp_key, 32'h66);
        chk("rel_count", 32'(count), 32'd1);
        cmd_valid = 1'b0;
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        model_cnt = 1;

`ifdef QQ_CMD_TIMEOUT_EN
        // REPL strobes, then the node never becomes ready again
        run_cmd(2'd2, 32'h77, 1'b0, 1'b0, 32'h88, 2, 1, 3, 32'hFFFF_FFFF, 2'd3,
                model_cnt, 11, "tmo_wait1");
        // ENQ never sees a ready node: no strobe at all
        run_cmd(2'd0, 32'h99, 1'b0, 1'b0, 32'h0, 3, 0, 0, 32'hFFFF_FFFF, 2'd3,
                model_cnt, 10, "tmo_issue");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Head value presented to the node: for DEQ/REPL the random head, otherwise
    // an unrelated value so ENQ responses cannot accidentally match it.
    function automatic logic [31:0] q_head_of(input logic [1:0] op, input logic [31:0] head,
                                              input logic [31:0] key);
        return (op == 2'd1 || op == 2'd2) ? head : ~key;
    endfunction

endmodule

// File: doc/qq_cmd_ctrl.md
QQ_CMD_CTRL -- requirements
Module: qq_cmd_ctrl

Interface
REQ-001 Parameters SHALL be: W, default 32, key width in bits; D, default 4, node depth; TO, default 64, timeout limit in cycles (used only with QQ_CMD_TIMEOUT_EN).
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  user command valid.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_op_i  in  2  operation: 00 ENQ, 01 DEQ, 10 REPL, 11 reserved.
- cmd_key_i  in  W  key for ENQ/REPL.
- q_rdy_i  in  1  node ready.
- q_full_i  in  1  node full flag.
- q_empty_i  in  1  node empty flag.
- q_head_i  in  W  node head key, RAM entry 0.
- q_enq_o  out  1  enqueue strobe to node.
- q_deq_o  out  1  dequeue strobe to node.
- q_repl_o  out  1  replace strobe to node.
- q_data_o  out  W  key driven to node data_lt_i.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_key_o  out  W  returned key.
- rsp_err_o  out  2  00 ok, 01 full, 10 empty, 11 timeout/illegal.
- count_o  out  $clog2(D+1)  tracked occupancy.

Function
REQ-003 States SHALL be IDLE, CHECK, ISSUE, WAIT0, WAIT1 and RESP.
REQ-004 cmd_ready_o SHALL be 1 only in IDLE; a handshake SHALL latch op and key into internal registers and move to CHECK.
REQ-005 In CHECK, the block SHALL reject without strobing as follows: ENQ with q_full_i=1 gives err 01; DEQ or REPL with q_empty_i=1 gives err 10, key all-ones; op 11 gives err 11. A rejected command SHALL go to RESP; otherwise the block SHALL go to ISSUE.
REQ-006 ISSUE SHALL hold until q_rdy_i=1, then assert exactly one strobe (q_enq_o, q_deq_o or q_repl_o) for exactly one cycle, drive q_data_o with the latched key in that same cycle, capture q_head_i into rsp_key_o for DEQ/REPL, and go to WAIT0.
REQ-007 WAIT0 SHALL last exactly one cycle and ignore q_rdy_i; WAIT1 SHALL remain until q_rdy_i=1, then go to RESP with err 00.
REQ-008 For ENQ, rsp_key_o SHALL echo the latched key.
REQ-009 q_data_o SHALL hold the latched key from CHECK through WAIT1, and SHALL be 0 in IDLE.
REQ-010 RESP SHALL hold rsp_valid_o=1 with stable rsp_key_o and rsp_err_o until rsp_ready_i=1, then return to IDLE; the next command SHALL NOT be accepted in that same cycle.
REQ-011 count_o SHALL increment on a successful ENQ, decrement on a successful DEQ, and stay unchanged on REPL and rejects; it SHALL saturate at D and at 0.
REQ-012 No more than one command SHALL be outstanding; strobes SHALL be mutually exclusive.

Reset
REQ-013 Asserting rst_n low SHALL immediately force state to IDLE and all outputs to 0, except cmd_ready_o which SHALL be 1; count_o SHALL reset to 0.
REQ-014 Reset asserted mid-command SHALL discard the command with no response; the node is reset on the same reset tree.
REQ-015 Deassertion SHALL be synchronised to clk (two-flop release); the first cmd_ready_o handshake SHALL be honoured no earlier than the second clk edge after release.

Configuration
REQ-016 When QQ_CMD_TIMEOUT_EN is defined, a counter SHALL clear on entering ISSUE and count cycles spent in ISSUE and WAIT1; on reaching TO it SHALL go to RESP with err 11 and key all-ones, with no further strobe.
REQ-017 Without QQ_CMD_TIMEOUT_EN, no counter SHALL exist, ISSUE/WAIT1 SHALL wait indefinitely, and parameter TO SHALL be unused.

Verification
REQ-018 Reset, then ENQ 0x10, 0x05, 0x20 -> three single-cycle q_enq_o pulses with q_data_o = 0x10, 0x05, 0x20; rsp_err_o=00 each; count_o=3.
REQ-019 With q_head_i=0x05 and count_o=3, DEQ -> one q_deq_o pulse, rsp_key_o=0x05, err 00, count_o=2.
REQ-020 With q_empty_i=1, DEQ -> no strobe, rsp_key_o=0xFFFFFFFF, err 10; with q_full_i=1 (D=4), ENQ 0x7 -> no strobe, err 01, count_o unchanged.
REQ-021 With rsp_ready_i=0 for 5 cycles after a response -> rsp_valid_o and rsp_key_o stable and cmd_ready_o=0 throughout; cmd_ready_o=1 the cycle after rsp_ready_i=1.
REQ-022 With QQ_CMD_TIMEOUT_EN defined, TO=8 and q_rdy_i held 0 after a q_repl_o pulse -> err 11 after 8 counted cycles; rst_n pulsed low during WAIT1 -> outputs 0 immediately, no response.
